uart_rx: RTL

Receive half of the MCU's 8-N-1 serial port, the companion to the transmitter on TXD. It synchronizes and glitch-filters the RXD pin and recovers bytes by mid-bit sampling against a runtime baud period. Each received byte is held in a one-entry buffer with a valid/read handshake toward the core's peripheral register interface. It sits beside the UART transmitter in the MCU top level and shares its baud and stability constants.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_filter.sv | 52 +++++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART constants, RX state encoding and frame sizes.
// Used by the UART receiver and its line filter.
package uart_rx_pkg;

  localparam int UART_STABLE_COUNT        = 2;
  localparam int UART_RX_BAUD_PERIOD_BITS = 16;
  localparam int UART_RX_BAUD_PERIOD      = 868;
  localparam int UART_RX_DATA_BITS        = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_filter.sv
// uart_rx_filter: 2-FF synchronizer plus stability filter for RXD.
// Ports: clk, reset (async), sync_reset, rxd_i (raw pin),
//        line_o (filtered line, idles 1), fall_o (1-cycle falling-edge strobe).
module uart_rx_filter #(
  parameter int STABLE_TIME = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_reset,
  input  logic rxd_i,
  output logic line_o,
  output logic fall_o
);

  localparam int CW = $clog2(STABLE_TIME + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          line_q;
  logic          fall_q;

  // cnt_q counts consecutive synchronized samples that differ from line_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      line_q <= 1'b1;
      fall_q <= 1'b0;
    end else if (sync_reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      line_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      fall_q <= 1'b0;
      if (sync_q[1] == line_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(STABLE_TIME - 1)) begin
        line_q <= sync_q[1];
        cnt_q  <= '0;
        fall_q <= line_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign line_o = line_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 receiver with mid-bit sampling and a one-byte holding buffer.
// Ports: clk, reset (async), sync_reset, RXD, baud_rate_period_m1, rx_read ->
//        SBUF_out, rx_valid, rx_overrun, rx_frame_error, rx_active.
// UART_RX_PARITY_EN adds an even-parity bit and the rx_parity_error port.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int STABLE_TIME      = UART_STABLE_COUNT,
  parameter int BAUD_PERIOD_BITS = UART_RX_BAUD_PERIOD_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sync_reset,
  input  logic                        RXD,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        rx_read,
  output logic [7:0]                  SBUF_out,
  output logic                        rx_valid,
  output logic                        rx_overrun,
  output logic                        rx_frame_error,
  output logic                        rx_active
`ifdef UART_RX_PARITY_EN
  ,
  output logic                        rx_parity_error
`endif
);

  localparam int DW = UART_RX_DATA_BITS;
  localparam int IW = $clog2(DW);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_e AFTER_DATA = RX_STOP;
`endif

  logic line;
  logic fall;

  uart_rx_filter #(
    .STABLE_TIME(STABLE_TIME)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .sync_reset(sync_reset),
    .rxd_i     (RXD),
    .line_o    (line),
    .fall_o    (fall)
  );

  rx_state_e             state_q;
  logic [BAUD_PERIOD_BITS-1:0] cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DW-1:0]         shift_q;
  logic                  fe_q;
  logic [7:0]            sbuf_q;
  logic                  valid_q;
  logic                  ovr_q;

  logic [BAUD_PERIOD_BITS-1:0] half;
  logic                  tick;
  logic                  commit;

  assign half = baud_rate_period_m1 >> 1;
  assign tick = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic pe_q;
  logic pe_pulse_q;
  assign commit = (state_q == RX_STOP) && tick && line && !pe_q;
  assign rx_parity_error = pe_pulse_q;
`else
  assign commit = (state_q == RX_STOP) && tick && line;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q       <= 1'b0;
      pe_pulse_q <= 1'b0;
`endif
    end else if (sync_reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q       <= 1'b0;
      pe_pulse_q <= 1'b0;
`endif
    end else begin
      fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pulse_q <= 1'b0;
`endif
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= half;
          if (fall) state_q <= RX_START;
        end
        RX_START: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (line) begin
            state_q <= RX_IDLE;
          end else begin
            state_q <= RX_DATA;
            cnt_q   <= baud_rate_period_m1;
            idx_q   <= '0;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {line, shift_q[DW-1:1]};
            cnt_q   <= baud_rate_period_m1;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IW'(DW - 1)) state_q <= AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            pe_q       <= ^{shift_q, line};
            pe_pulse_q <= ^{shift_q, line};
            cnt_q      <= baud_rate_period_m1;
            state_q    <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q   <= half;
            fe_q    <= !line;
            state_q <= line ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          // A held-low line must return high before a new start is armed.
          cnt_q <= half;
          if (line) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // Holding buffer: a read in the commit cycle makes room for the new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbuf_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (sync_reset) begin
      sbuf_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (commit) begin
      if (!valid_q || rx_read) begin
        sbuf_q  <= shift_q;
        valid_q <= 1'b1;
        if (rx_read) ovr_q <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (rx_read && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign SBUF_out       = sbuf_q;
  assign rx_valid       = valid_q;
  assign rx_overrun     = ovr_q;
  assign rx_frame_error = fe_q;
  assign rx_active      = (state_q != RX_IDLE);

endmodule
